xc_malu_seq: RTL

Sequencing and state-holding companion to the multi-cycle MALU datapath (the `xc_malu_mul` step logic). It owns the `count`, `acc`, `arg_0` and `arg_1` registers the step logic reads, and registers the `n_acc` and `n_arg_0` values it returns. It also answers that logic's packed-adder requests, and runs the valid/ready handshake with the issuing pipeline stage. It sits between the execute stage and the combinational step datapath.

---
 rtl/xc_malu_pkg.sv | 32 +++
 rtl/xc_malu_seq_if.sv | 47 ++++
 rtl/xc_malu_padd.sv | 35 +++
 rtl/xc_malu_seq.sv | 102 ++++++++++
 4 files changed

// File: rtl/xc_malu_pkg.sv
// Shared MALU definitions: sequencer FSM encoding, counter width default and the
// packed-width one-hot codes used by the packed adder.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } malu_state_e;

    localparam int unsigned CwDefault = 6;

    // Packed-width vector order is {pw_32, pw_16, pw_8, pw_4, pw_2}.
    localparam logic [4:0] Pw32 = 5'b10000;
    localparam logic [4:0] Pw16 = 5'b01000;
    localparam logic [4:0] Pw8  = 5'b00100;
    localparam logic [4:0] Pw4  = 5'b00010;
    localparam logic [4:0] Pw2  = 5'b00001;

    // Bit set at every element LSB; anything other than a single narrower width
    // falls back to one 32-bit element.
    function automatic logic [31:0] elem_lsb_mask(logic [4:0] pw);
        case (pw)
            Pw16:    return 32'h0001_0001;
            Pw8:     return 32'h0101_0101;
            Pw4:     return 32'h1111_1111;
            Pw2:     return 32'h5555_5555;
            default: return 32'h0000_0001;
        endcase
    endfunction

endpackage

// File: rtl/xc_malu_seq_if.sv
// Bundle between the MALU sequencer, the issuing pipeline stage and the step logic.
interface xc_malu_seq_if
    import xc_malu_pkg::*;
#(
    parameter int unsigned CW = CwDefault
);
    logic          valid;
    logic          flush;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic          pw_32;
    logic          pw_16;
    logic          pw_8;
    logic          pw_4;
    logic          pw_2;
    logic [CW-1:0] count;
    logic [63:0]   acc;
    logic [31:0]   arg_0;
    logic [31:0]   arg_1;
    logic [63:0]   n_acc;
    logic [31:0]   n_arg_0;
    logic          step_ready;
    logic [31:0]   padd_lhs;
    logic [31:0]   padd_rhs;
    logic          padd_sub;
    logic          padd_cin;
    logic          padd_cen;
    logic [32:0]   padd_cout;
    logic [31:0]   padd_result;
    logic [63:0]   result;
    logic          ready;
    logic          busy;

    modport master (
        output valid, flush, rs1, rs2, pw_32, pw_16, pw_8, pw_4, pw_2,
        output n_acc, n_arg_0, step_ready,
        output padd_lhs, padd_rhs, padd_sub, padd_cin, padd_cen,
        input  count, acc, arg_0, arg_1, padd_cout, padd_result, result, ready, busy
    );

    modport slave (
        input  valid, flush, rs1, rs2, pw_32, pw_16, pw_8, pw_4, pw_2,
        input  n_acc, n_arg_0, step_ready,
        input  padd_lhs, padd_rhs, padd_sub, padd_cin, padd_cen,
        output count, acc, arg_0, arg_1, padd_cout, padd_result, result, ready, busy
    );
endinterface

// File: rtl/xc_malu_padd.sv
// Combinational packed adder: per-element ripple with forced element carry-in,
// optional carry suppression, full carry vector reported.
module xc_malu_padd
    import xc_malu_pkg::*;
(
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic        sub,
    input  logic        cin,
    input  logic        cen,
    input  logic [4:0]  pw,
    output logic [31:0] result,
    output logic [32:0] cout
);
    logic [31:0] rhs_eff;
    logic [31:0] lsb;
    logic [32:0] carry;
    logic        c_in;

    always_comb begin
        rhs_eff  = rhs ^ {32{sub}};
        lsb      = elem_lsb_mask(pw);
        carry    = '0;
        carry[0] = cin;
        result   = '0;
        c_in     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            // Element boundaries restart from cin; the previous element's carry is dropped.
            c_in         = cen & (lsb[i] ? cin : carry[i]);
            result[i]    = lhs[i] ^ rhs_eff[i] ^ c_in;
            carry[i + 1] = cen & ((lhs[i] & rhs_eff[i]) | (c_in & (lhs[i] ^ rhs_eff[i])));
        end
        cout = carry;
    end
endmodule

// File: rtl/xc_malu_seq.sv
// MALU sequencer: owns the step registers, runs IDLE/RUN/DONE with a saturating
// step-count watchdog, and hosts the packed adder for the step logic.
module xc_malu_seq
    import xc_malu_pkg::*;
#(
    parameter int unsigned CW = CwDefault
) (
    input logic          clock,
    input logic          resetn,
    xc_malu_seq_if.slave bus
);
    localparam logic [CW-1:0] CountMax = '1;

    malu_state_e   state;
    logic [CW-1:0] count_q;
    logic [63:0]   acc_q;
    logic [31:0]   arg_0_q;
    logic [31:0]   arg_1_q;
    logic [63:0]   result_q;
    logic          ready_q;
    logic          busy_q;
    logic          abort;
    logic          at_max;

    assign abort  = bus.flush || (state == StRun && !bus.valid);
    assign at_max = (count_q == CountMax);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            arg_0_q  <= '0;
            arg_1_q  <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (abort) begin
            state    <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            arg_0_q  <= '0;
            arg_1_q  <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.valid) begin
                        state   <= StRun;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        acc_q   <= '0;
                        arg_0_q <= bus.rs1;
                        arg_1_q <= bus.rs2;
                    end
                end
                StRun: begin
                    acc_q   <= bus.n_acc;
                    arg_0_q <= bus.n_arg_0;
                    if (!at_max) begin
                        count_q <= count_q + 1'b1;
                    end
                    // Final step's update lands on the same edge that enters DONE.
                    if (bus.step_ready || at_max) begin
                        state    <= StDone;
                        busy_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        result_q <= bus.n_acc;
                    end
                end
                StDone: begin
                    if (!bus.valid) begin
                        state   <= StIdle;
                        ready_q <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.count  = count_q;
    assign bus.acc    = acc_q;
    assign bus.arg_0  = arg_0_q;
    assign bus.arg_1  = arg_1_q;
    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;

    xc_malu_padd u_padd (
        .lhs    (bus.padd_lhs),
        .rhs    (bus.padd_rhs),
        .sub    (bus.padd_sub),
        .cin    (bus.padd_cin),
        .cen    (bus.padd_cen),
        .pw     ({bus.pw_32, bus.pw_16, bus.pw_8, bus.pw_4, bus.pw_2}),
        .result (bus.padd_result),
        .cout   (bus.padd_cout)
    );
endmodule
